// File: rtl/regs_wb_sched_if.sv
// Requester-side bus of the writeback scheduler: per-requester valid/addr/data,
// the global stall, and the combinational per-requester grant (req_ready).
// The master modport is the requester side; the slave modport is the scheduler.
interface regs_wb_sched_if #(
    parameter int NREQ = 6
);
    logic                stall;
    logic [NREQ-1:0]     req_valid;
    logic [3*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;

    modport master (
        output stall,
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  stall,
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regs_wb_sched.sv
// Writeback scheduler for the 8080 register file (8 x 8-bit, four write ports).
// Each cycle a rotating round-robin scan grants up to four requesters whose
// target addresses are mutually distinct. The k-th grant in scan order is
// registered onto write port k. busy flags the addresses being written by the
// registered ports.
// Optional feature: define REGS_WB_FWD_EN to add the fwd_addr/fwd_hit/fwd_data
// forwarding lookup against the registered write ports.
module regs_wb_sched #(
    parameter int NREQ  = 6,
    parameter int NPORT = 4
) (
    input  logic                clk,
    input  logic                reset,
    regs_wb_sched_if.slave      req_if,
    output logic                wen0,
    output logic                wen1,
    output logic                wen2,
    output logic                wen3,
    output logic [2:0]          waddr0,
    output logic [2:0]          waddr1,
    output logic [2:0]          waddr2,
    output logic [2:0]          waddr3,
    output logic [7:0]          wdata0,
    output logic [7:0]          wdata1,
    output logic [7:0]          wdata2,
    output logic [7:0]          wdata3,
    output logic [7:0]          busy,
    output logic [2:0]          rr_ptr_o
`ifdef REGS_WB_FWD_EN
    ,
    input  logic [2:0]          fwd_addr,
    output logic                fwd_hit,
    output logic [7:0]          fwd_data
`endif
);

    // Registered write ports and round-robin pointer.
    logic [NPORT-1:0] wen_q,   wen_d;
    logic [2:0]       waddr_q [NPORT];
    logic [2:0]       waddr_d [NPORT];
    logic [7:0]       wdata_q [NPORT];
    logic [7:0]       wdata_d [NPORT];
    logic [2:0]       rr_ptr_q, rr_ptr_d;

    // Per-requester views of the packed request buses.
    logic [2:0]       req_addr_a [NREQ];
    logic [7:0]       req_data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_addr_a[i] = req_if.req_addr[3*i +: 3];
        assign req_data_a[i] = req_if.req_data[8*i +: 8];
    end

    // Grant scan: walk requesters from rr_ptr, granting distinct addresses
    // into successive ports until the ports run out.
    always_comb begin
        logic [7:0]  addr_used;
        logic [2:0]  cnt;
        logic [3:0]  sum;
        logic [2:0]  idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        addr_used      = '0;
        cnt            = '0;
        sum            = '0;
        idx            = '0;
        req_if.req_ready = '0;
        wen_d          = '0;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        rr_ptr_d       = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + 4'(k);
            if (sum >= 4'(NREQ)) begin
                sum = sum - 4'(NREQ);
            end
            idx = sum[2:0];
            if (!req_if.stall && req_if.req_valid[idx] &&
                (cnt < 3'(NPORT)) && !addr_used[req_addr_a[idx]]) begin
                req_if.req_ready[idx]       = 1'b1;
                addr_used[req_addr_a[idx]]  = 1'b1;
                wen_d[cnt[1:0]]             = 1'b1;
                waddr_d[cnt[1:0]]           = req_addr_a[idx];
                wdata_d[cnt[1:0]]           = req_data_a[idx];
                cnt                         = cnt + 3'd1;
                rr_ptr_d = (idx == 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
            end
        end
    end

    // Register the write ports and pointer; reset discards any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the port address/data registers are reset too because their
            // reset value is visible on the outputs, not just their enable.
            wen_q    <= '0;
            waddr_q  <= '{default: '0};
            wdata_q  <= '{default: '0};
            rr_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values regardless of statement order.
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // busy marks each address that a registered port is writing this edge.
    always_comb begin
        busy = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (wen_q[k]) begin
                busy[waddr_q[k]] = 1'b1;
            end
        end
    end

`ifdef REGS_WB_FWD_EN
    // Forwarding lookup; port addresses are unique so at most one port matches.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (wen_q[k] && (waddr_q[k] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wdata_q[k];
            end
        end
    end
`endif

    assign wen0     = wen_q[0];
    assign wen1     = wen_q[1];
    assign wen2     = wen_q[2];
    assign wen3     = wen_q[3];
    assign waddr0   = waddr_q[0];
    assign waddr1   = waddr_q[1];
    assign waddr2   = waddr_q[2];
    assign waddr3   = waddr_q[3];
    assign wdata0   = wdata_q[0];
    assign wdata1   = wdata_q[1];
    assign wdata2   = wdata_q[2];
    assign wdata3   = wdata_q[3];
    assign rr_ptr_o = rr_ptr_q;

endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
- Writeback scheduler in front of the 8080 register file (8 x 8-bit, four write ports wen0..wen3).
- Arbitrates up to NREQ writeback requesters (ALU, load unit, INX/DCX pair logic, etc.) onto the four write ports each cycle.
- Uses rotating round-robin priority and suppresses same-address collisions.
- Outputs are registered, one pipeline stage, and drive the register-file write ports directly.

Parameters:
- NREQ, 6, number of writeback requesters (2..8).
- NPORT, 4, number of register-file write ports driven; fixed at 4 for this register file.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  when high, no grants this cycle.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  3*NREQ  register address, requester i at [3i+2:3i].
- req_data  input  8*NREQ  write data, requester i at [8i+7:8i].
- req_ready  output  NREQ  combinational grant; transfer occurs when valid & ready.
- wen0..wen3  output  1 each  registered write enables to register file.
- waddr0..waddr3  output  3 each  registered write addresses.
- wdata0..wdata3  output  8 each  registered write data.
- busy  output  8  bit a set when any wenK is high with waddrK==a (write lands at this edge).
- rr_ptr_o  output  3  current round-robin start index (debug).

Behaviour:
- Reset: all wenK=0, waddrK=0, wdataK=0, rr_ptr=0, busy=0. Asserting reset mid-operation discards any registered write and produces no wen pulse.
- Requester rule: once valid is high, addr and data are held stable until the handshake completes.
- Grant scan (combinational): visit requesters rr_ptr, rr_ptr+1, ..., wrapping mod NREQ. Grant requester i only if all of these hold:
  - req_valid[i]=1,
  - stall=0,
  - fewer than NPORT already granted,
  - req_addr[i] differs from every address already granted this cycle.
- Losers of an address collision, and those past the 4th grant, keep ready=0 and retry next cycle.
- Port mapping: the k-th grant in scan order goes to port k; unused ports get wen=0 with addr/data held at their previous values.
- Latency: on the granting edge, wenK/waddrK/wdataK register. The register file writes at the following edge, 1 cycle after handshake.
- Distinct addresses per cycle guarantee the register file never sees two enabled ports with equal addresses.
- Pointer update: if at least one grant, rr_ptr <= (index of last granted requester + 1) mod NREQ. If no grant, including during stall, rr_ptr is held.
- stall=1: req_ready=0 for all requesters; the next registered wenK are all 0.
- busy is derived combinationally from the registered wen/waddr outputs.
- NREQ < NPORT: high ports are never enabled.

Optional Feature:
- Macro REGS_WB_FWD_EN.
- Defined: adds ports fwd_addr (input 3), fwd_hit (output 1), fwd_data (output 8).
  - fwd_hit=1 when some wenK=1 and waddrK==fwd_addr; fwd_data is that wdataK.
  - Uniqueness of addresses makes the match unambiguous.
  - fwd_hit=0 and fwd_data=0 otherwise and during reset.
- Undefined: ports absent, no forwarding logic.

Test Plan:
- Reset with all requesters valid: during reset all wenK=0, busy=0. On the first edge after release, req 0..3 are granted (addr 0..3), wen0..3=1 with waddr0..3=0,1,2,3, and rr_ptr becomes 4.
- Collision, rr_ptr=0: req0 and req2 both addr=7 with data 0x11 and 0x22. Required response: only req0 granted; waddr0=7, wdata0=0x11; req2 granted the next cycle with wdata0=0x22; busy[7]=1 on both cycles.
- Six valid requests, distinct addresses: cycle 1 grants req0..3; cycle 2 grants req4,5 on ports 0,1 with wen2=wen3=0; rr_ptr after cycle 2 is 0.
- Fairness: req5 held continuously with req0..4 always valid. Required response: req5 granted within 2 cycles and never starved over 20 cycles.
- stall=1 for 3 cycles with req1 valid: req_ready=0, all wen=0, rr_ptr unchanged. On release, req1 is granted in the same cycle.
- With REGS_WB_FWD_EN defined: after granting addr=5, data=0xA5 and setting fwd_addr=5, the following cycle shows fwd_hit=1, fwd_data=0xA5. With fwd_addr=6, fwd_hit=0.
